// File: rtl/node_route_sequencer_if.sv
// Signal bundle for node_route_sequencer: sensor samples, route programming strobes and
// motion outputs, with a master view (stimulus side) and a slave view (the sequencer).
interface node_route_sequencer_if;
    logic [11:0] left_sensor;
    logic [11:0] center_sensor;
    logic [11:0] right_sensor;
    logic        start;
    logic        route_we;
    logic [3:0]  route_addr;
    logic [1:0]  route_data;
    logic [4:0]  route_len;
    logic [1:0]  cmd;
    logic [4:0]  node_count;
    logic        busy;
    logic        done;
    logic        turn_timeout;
    logic        led;
    logic [2:0]  state_dbg;

    // start and route_we are single-cycle strobes without a ready: each is taken on a
    // rising clk edge only while busy is low, and a strobe seen while busy is dropped.
    modport master (
        output left_sensor, center_sensor, right_sensor, start,
        output route_we, route_addr, route_data, route_len,
        input  cmd, node_count, busy, done, turn_timeout, led, state_dbg
    );

    modport slave (
        input  left_sensor, center_sensor, right_sensor, start,
        input  route_we, route_addr, route_data, route_len,
        output cmd, node_count, busy, done, turn_timeout, led, state_dbg
    );
endinterface

// File: rtl/node_route_sequencer.sv
// Line-following route sequencer: tracks the line, counts nodes and executes a stored
// table of straight/left/right/stop decisions, with blanking and bounded spin turns.
module node_route_sequencer #(
    parameter int TH              = 500,
    parameter int BLANK_CYCLES    = 3_125_000,
    parameter int TURN_MIN_CYCLES = 1_000_000,
    parameter int TURN_MAX_CYCLES = 6_250_000
) (
    input logic                   clk,
    input logic                   rst,
    node_route_sequencer_if.slave bus
);
    localparam int BW = $clog2(BLANK_CYCLES + 2);
    localparam int TW = $clog2(TURN_MAX_CYCLES + 2);

    localparam logic [11:0]   TH12       = 12'(TH);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);
    localparam logic [TW-1:0] TURN_MIN   = TW'(TURN_MIN_CYCLES);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_MAX_CYCLES - 1);

    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_FWD   = 2'b01;
    localparam logic [1:0] CMD_SPINL = 2'b10;
    localparam logic [1:0] CMD_SPINR = 2'b11;

    localparam logic [1:0] R_STRAIGHT = 2'b00;
    localparam logic [1:0] R_LEFT     = 2'b01;
    localparam logic [1:0] R_RIGHT    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FOLLOW = 3'd1,
        S_BLANK  = 3'd2,
        S_TURN   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state;
    logic [4:0]      index;
    logic [4:0]      len_q;
    logic [BW-1:0]   blank_cnt;
    logic [TW-1:0]   turn_cnt;
    logic [1:0]      cmd_q;
    logic [4:0]      node_count_q;
    logic            busy_q;
    logic            done_q;
    logic            timeout_q;
    logic            led_q;
    logic [1:0]      route_tab [16];

    logic       node;
    logic       reacquire;
    logic       len_ok;
    logic [1:0] entry;

    assign node      = (bus.left_sensor > TH12) && (bus.center_sensor > TH12) &&
                       (bus.right_sensor > TH12);
    assign reacquire = (bus.center_sensor > TH12) && (bus.left_sensor <= TH12) &&
                       (bus.right_sensor <= TH12);
    assign len_ok    = (bus.route_len != 5'd0) && (bus.route_len <= 5'd16);
    assign entry     = route_tab[index[3:0]];

    // Table contents carry no reset; only the programming path may change them.
    always_ff @(posedge clk) begin
        if (bus.route_we && !busy_q) begin
            route_tab[bus.route_addr] <= bus.route_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            index        <= 5'd0;
            len_q        <= 5'd0;
            blank_cnt    <= '0;
            turn_cnt     <= '0;
            cmd_q        <= CMD_STOP;
            node_count_q <= 5'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start && len_ok) begin
                        state        <= S_FOLLOW;
                        cmd_q        <= CMD_FWD;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        index        <= 5'd0;
                        node_count_q <= 5'd0;
                        timeout_q    <= 1'b0;
                        len_q        <= bus.route_len;
                    end
                end
                S_FOLLOW: begin
                    if (node) begin
                        index        <= index + 5'd1;
                        node_count_q <= node_count_q + 5'd1;
                        led_q        <= ~led_q;
                        case (entry)
                            R_STRAIGHT: begin
                                state     <= S_BLANK;
                                blank_cnt <= BLANK_LOAD;
                            end
                            R_LEFT: begin
                                state    <= S_TURN;
                                cmd_q    <= CMD_SPINL;
                                turn_cnt <= '0;
                            end
                            R_RIGHT: begin
                                state    <= S_TURN;
                                cmd_q    <= CMD_SPINR;
                                turn_cnt <= '0;
                            end
                            default: begin
                                state  <= S_DONE;
                                cmd_q  <= CMD_STOP;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                S_TURN: begin
                    // Reacquire is checked first so it wins over a same-cycle timeout.
                    if ((turn_cnt >= TURN_MIN) && reacquire) begin
                        state     <= S_BLANK;
                        cmd_q     <= CMD_FWD;
                        blank_cnt <= BLANK_LOAD;
                        turn_cnt  <= '0;
                    end else if (turn_cnt == TURN_LAST) begin
                        state     <= S_BLANK;
                        cmd_q     <= CMD_FWD;
                        blank_cnt <= BLANK_LOAD;
                        turn_cnt  <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        turn_cnt <= turn_cnt + TW'(1);
                    end
                end
                S_BLANK: begin
                    if (blank_cnt <= BW'(1)) begin
                        blank_cnt <= '0;
                        if (index == len_q) begin
                            state  <= S_DONE;
                            cmd_q  <= CMD_STOP;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_FOLLOW;
                        end
                    end else begin
                        blank_cnt <= blank_cnt - BW'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    cmd_q  <= CMD_STOP;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd          = cmd_q;
    assign bus.node_count   = node_count_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.turn_timeout = timeout_q;
    assign bus.led          = led_q;
    assign bus.state_dbg    = state;
endmodule
